bus_mux_arbiter: RTL

//  Round-robin arbiter that shares one multiplexed data bus among NUM_REQ requesters.
//  It owns the select lines of a multiplexer instance and grants the bus to one

---
 rtl/gpp_bus_pkg.sv | 34 +++
 rtl/bus_mux_arbiter_mux.sv | 14 +
 rtl/bus_mux_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/gpp_bus_pkg.sv
// Shared types and the round-robin search helper for the GPP bus arbiter.
package gpp_bus_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    // Widest request vector the helper handles; callers zero-extend into it.
    localparam int RR_MAX_REQ = 16;
    localparam int RR_IDX_W   = 4;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] index;
    } rr_pick_t;

    // First asserted request at or after pointer, ascending, wrapping at num_req.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                         input logic [RR_IDX_W-1:0]   pointer,
                                         input int unsigned           num_req);
        rr_pick_t            r;
        int unsigned         idx;
        logic [RR_IDX_W-1:0] idx_n;
        r = '0;
        for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
            idx   = (int'(pointer) + k) % num_req;
            idx_n = RR_IDX_W'(idx);
            if ((k < num_req) && !r.found && req[idx_n]) begin
                r.found = 1'b1;
                r.index = idx_n;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_mux_arbiter_mux.sv
// Plain N:1 data multiplexer driven by the arbiter's registered select.
module multiplexer #(
    parameter int SEL_WIDTH  = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic [DATA_WIDTH-1:0] data [2**SEL_WIDTH-1:0],
    output logic [DATA_WIDTH-1:0] bus_out
);

    // Zero-latency selection of the current owner's word.
    assign bus_out = data[sel];

endmodule

// File: rtl/bus_mux_arbiter.sv
// Round-robin owner of a shared data bus with bounded hold time.
module bus_mux_arbiter
    import gpp_bus_pkg::*;
#(
    parameter int SEL_WIDTH  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_HOLD   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2**SEL_WIDTH-1:0] req,
    input  logic [DATA_WIDTH-1:0]   data [2**SEL_WIDTH-1:0],
    output logic [2**SEL_WIDTH-1:0] grant,
    output logic [SEL_WIDTH-1:0]    sel,
    output logic [DATA_WIDTH-1:0]   bus_out,
    output logic                    bus_valid
);

    localparam int NUM_REQ = 2**SEL_WIDTH;
    localparam int HOLD_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;

    arb_state_t          state;
    logic [SEL_WIDTH-1:0] pointer;
    logic [HOLD_W-1:0]    hold_cnt;

    logic [SEL_WIDTH-1:0] next_ptr;
    logic                 owner_req;
    logic                 timeout_hit;
    rr_pick_t             pick_idle;
    rr_pick_t             pick_rel;
    rr_pick_t             pick_to;
    logic                 unused_pick;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_WIDTH-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Candidate winners for each way the bus can change hands this cycle.
    always_comb begin
        next_ptr    = sel + SEL_WIDTH'(1);
        owner_req   = |(req & grant);
        timeout_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        pick_idle   = rr_pick(RR_MAX_REQ'(req), RR_IDX_W'(pointer), NUM_REQ);
        pick_rel    = rr_pick(RR_MAX_REQ'(req), RR_IDX_W'(next_ptr), NUM_REQ);
        pick_to     = rr_pick(RR_MAX_REQ'(req & ~grant), RR_IDX_W'(next_ptr), NUM_REQ);
    end

    // Index bits above SEL_WIDTH are always zero; fold them away explicitly.
    assign unused_pick = ^{pick_idle, pick_rel, pick_to};

    // Arbitration FSM: idle grant, release hand-off and hold-time preemption.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            sel      <= '0;
            pointer  <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_idle.found) begin
                        state    <= ARB_BUSY;
                        grant    <= onehot(SEL_WIDTH'(pick_idle.index));
                        sel      <= SEL_WIDTH'(pick_idle.index);
                        hold_cnt <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (!owner_req) begin
                        pointer <= next_ptr;
                        if (pick_rel.found) begin
                            grant    <= onehot(SEL_WIDTH'(pick_rel.index));
                            sel      <= SEL_WIDTH'(pick_rel.index);
                            hold_cnt <= '0;
                        end else begin
                            state <= ARB_IDLE;
                            grant <= '0;
                        end
                    end else if (timeout_hit) begin
                        hold_cnt <= '0;
                        if (pick_to.found) begin
                            pointer <= next_ptr;
                            grant   <= onehot(SEL_WIDTH'(pick_to.index));
                            sel     <= SEL_WIDTH'(pick_to.index);
                        end
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign bus_valid = |grant;

    multiplexer #(
        .SEL_WIDTH (SEL_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux (
        .sel    (sel),
        .data   (data),
        .bus_out(bus_out)
    );

endmodule
